laser_mem_arbiter: RTL

Parametrised N-channel arbiter for the shared video/system RAM on the F14Mx2 domain, replacing the fixed download/eraser/VDC priority mux that currently selects what drives the dpram port. Each requester gets a req/ack handshake, fixed or round-robin priority, and a tagged read-return path that accounts for the RAM's read latency. The block sits between the downloader, eraser and VTL chip masters and the single-port RAM.

---
 rtl/laser_mem_pkg.sv | 21 ++
 rtl/laser_mem_arbiter_rr_pick.sv | 34 +++
 rtl/laser_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/laser_mem_pkg.sv
// Shared definitions for the F14Mx2-domain video/system RAM arbiter.
// Holds channel assignments, default geometry and the read-return tag type.
package laser_mem_pkg;

    localparam int unsigned CH_DOWNLOAD = 0;
    localparam int unsigned CH_ERASER   = 1;
    localparam int unsigned CH_VDC      = 2;

    localparam int unsigned DEF_N_CH = 3;
    localparam int unsigned DEF_AW   = 25;
    localparam int unsigned DEF_DW   = 8;

    // The tag channel field is wide enough for any practical channel count.
    localparam int unsigned TAG_CH_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
    } rd_tag_t;

endpackage

// File: rtl/laser_mem_arbiter_rr_pick.sv
// Rotated priority encoder: the first eligible channel at or after 'start'
// wins, wrapping around. With start=0 this is a plain fixed-priority encoder.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [N-1:0] rot;

    always_comb begin
        int unsigned pos;
        // Rotate so that bit 0 of rot corresponds to channel 'start'.
        rot    = N'({elig, elig} >> start);
        found  = 1'b0;
        winner = '0;
        pos    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = 32'(start) + i;
                if (pos >= N) begin
                    pos = pos - N;
                end
                winner = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/laser_mem_arbiter.sv
// N-channel arbiter for the shared single-port RAM: req/ack per channel, fixed
// or round-robin priority, registered issue and a tagged read-return pipeline.
module laser_mem_arbiter
    import laser_mem_pkg::*;
#(
    parameter int unsigned N_CH   = DEF_N_CH,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned RR     = 0
) (
    input  logic                     F14Mx2,
    input  logic                     CPU_RESET,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*AW-1:0]       addr,
    input  logic [N_CH*DW-1:0]       din,
    output logic [N_CH-1:0]          ack,
    output logic [N_CH-1:0]          rvalid,
    output logic [DW-1:0]            dout,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_din,
    output logic                     mem_wr,
    input  logic [DW-1:0]            mem_q,
    output logic [$clog2(N_CH)-1:0]  grant_id,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(N_CH);

    logic [N_CH-1:0] elig;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   start;
    logic [IW-1:0]   pick;
    logic            found;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_din;
    logic            sel_we;
    rd_tag_t         issue_tag;
    rd_tag_t         rd_pipe [RD_LAT];

    // A channel acked this cycle has not yet seen it, so it must not win again.
    assign elig = req & ~ack;

    always_comb begin
        start = '0;
        if (RR != 0) begin
            if (last_grant == IW'(N_CH - 1)) begin
                start = '0;
            end else begin
                start = last_grant + 1'b1;
            end
        end
    end

    rr_pick #(
        .N  (N_CH),
        .IW (IW)
    ) u_pick (
        .elig   (elig),
        .start  (start),
        .winner (pick),
        .found  (found)
    );

    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (pick == IW'(i)) begin
                sel_addr = addr[i*AW +: AW];
                sel_din  = din[i*DW +: DW];
                sel_we   = we[i];
            end
        end
    end

    // issue_tag lines up with the RAM issue cycle; the RD_LAT-deep pipe then
    // presents it while mem_q is valid, and dout/rvalid register one stage later.
    always_ff @(posedge F14Mx2 or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            ack        <= '0;
            mem_wr     <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            grant_id   <= '0;
            last_grant <= IW'(N_CH - 1);
            issue_tag  <= '0;
            rvalid     <= '0;
            dout       <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                rd_pipe[k] <= '0;
            end
        end else begin
            ack       <= '0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            issue_tag <= '0;
            if (found) begin
                ack             <= N_CH'(1) << pick;
                mem_addr        <= sel_addr;
                mem_din         <= sel_din;
                mem_wr          <= sel_we;
                grant_id        <= pick;
                busy            <= 1'b1;
                last_grant      <= pick;
                issue_tag.valid <= ~sel_we;
                issue_tag.ch    <= TAG_CH_W'(pick);
            end

            rd_pipe[0] <= issue_tag;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end

            rvalid <= '0;
            if (rd_pipe[RD_LAT-1].valid) begin
                rvalid <= N_CH'(1) << rd_pipe[RD_LAT-1].ch;
                dout   <= mem_q;
            end
        end
    end

endmodule
